// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational fetch lookup; execute-stage resolution updates the table and raises a one-cycle redirect.
module branch_predictor #(
  parameter int WIDTH = 32,
  parameter int IDX   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_add,
  output logic [WIDTH-1:0] next_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic             ex_taken,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             ex_pred_taken,
  input  logic [WIDTH-1:0] ex_pred_target,
  output logic             flush,
  output logic [WIDTH-1:0] save_pc,
  output logic [WIDTH-1:0] branch_pc
);
  localparam int NE   = 2**IDX;
  localparam int TAGW = WIDTH - IDX - 2;

  localparam logic [1:0] SN = 2'b00;
  localparam logic [1:0] WN = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;

  logic [NE-1:0]                  valid_q;
  logic [NE-1:0][TAGW-1:0]        tag_q;
  logic [NE-1:0][WIDTH-1:0]       tgt_q;
  logic [NE-1:0][1:0]             cnt_q;
  logic                           flush_q, flush_d;
  logic [WIDTH-1:0]               save_q, save_d, bpc_q, bpc_d;

  // fetch-side lookup
  logic [IDX-1:0]   f_idx;
  logic [TAGW-1:0]  f_tag;
  logic             f_hit;
  logic [WIDTH-1:0] seq_pc;

  assign f_idx      = pc_add[IDX+1:2];
  assign f_tag      = pc_add[WIDTH-1:IDX+2];
  assign f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign seq_pc     = pc_add + WIDTH'(4);
  assign pred_taken = f_hit && cnt_q[f_idx][1];
  assign next_pc    = pred_taken ? tgt_q[f_idx] : seq_pc;

  // execute-side resolution
  logic [IDX-1:0]   e_idx;
  logic [TAGW-1:0]  e_tag;
  logic             e_hit, upd, mispred;
  logic [WIDTH-1:0] e_seq;
  logic [1:0]       cnt_new;

  assign e_idx   = ex_pc[IDX+1:2];
  assign e_tag   = ex_pc[WIDTH-1:IDX+2];
  assign e_hit   = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign e_seq   = ex_pc + WIDTH'(4);
  // ex_valid during a flush belongs to a squashed wrong-path instruction
  assign upd     = ex_valid && !flush_q;
  assign mispred = (ex_pred_taken != ex_taken) ||
                   (ex_taken && (ex_pred_target != ex_target));

  always_comb begin
    cnt_new = cnt_q[e_idx];
    if (!e_hit)
      cnt_new = ex_taken ? WT : WN;
    else if (ex_taken && cnt_q[e_idx] != ST)
      cnt_new = cnt_q[e_idx] + 2'd1;
    else if (!ex_taken && cnt_q[e_idx] != SN)
      cnt_new = cnt_q[e_idx] - 2'd1;
  end

  // save_pc=0 tells the PC mux to take branch_pc; a not-taken redirect that
  // wraps to 0 still lands correctly because branch_pc carries the same value
  always_comb begin
    flush_d = 1'b0;
    save_d  = save_q;
    bpc_d   = bpc_q;
    if (upd && mispred) begin
      flush_d = 1'b1;
      save_d  = ex_taken ? '0 : e_seq;
      bpc_d   = ex_taken ? ex_target : e_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      for (int i = 0; i < NE; i++) cnt_q[i] <= WN;
      flush_q <= 1'b0;
      save_q  <= '0;
      bpc_q   <= '0;
    end else begin
      flush_q <= flush_d;
      save_q  <= save_d;
      bpc_q   <= bpc_d;
      if (upd) begin
        valid_q[e_idx] <= 1'b1;
        tag_q[e_idx]   <= e_tag;
        cnt_q[e_idx]   <= cnt_new;
        if (ex_taken || !e_hit) tgt_q[e_idx] <= ex_target;
      end
    end
  end

  assign flush     = flush_q;
  assign save_pc   = save_q;
  assign branch_pc = bpc_q;
endmodule
